// File: rtl/bin_to_bcd_seq_if.sv
// Bus between a requester and bin_to_bcd_seq: start/bin request side and
// busy/done/bcd/overflow result side. When BCD_BLANK_EN is defined the bus
// also carries the per-digit leading-zero blanking flags.
interface bin_to_bcd_seq_if #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
);
    logic                  start;
    logic [BIN_W-1:0]      bin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic                  overflow;
`ifdef BCD_BLANK_EN
    logic [DIGITS-1:0]     blank;
`endif

    // Requester side: issues start/bin, observes the result
    modport master (
        output start,
        output bin,
        input  busy,
        input  done,
        input  bcd,
`ifdef BCD_BLANK_EN
        input  blank,
`endif
        input  overflow
    );

    // Converter side
    modport slave (
        input  start,
        input  bin,
        output busy,
        output done,
        output bcd,
`ifdef BCD_BLANK_EN
        output blank,
`endif
        output overflow
    );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble, one input bit per clock).
// start in IDLE captures bin; BIN_W shift cycles later bcd/overflow are loaded
// and done pulses for one cycle. Values that do not fit in DIGITS digits are
// reduced modulo 10^DIGITS and flagged with overflow.
// Optional macro BCD_BLANK_EN adds a registered leading-zero blank vector.
module bin_to_bcd_seq #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic              clk,
    input  logic              rst,
    bin_to_bcd_seq_if.slave   bus
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    if (BIN_W < 1 || BIN_W > 32) begin : g_bad_bin_w
        $error("bin_to_bcd_seq: BIN_W must be in 1..32");
    end
    if (DIGITS < 1 || DIGITS > 10) begin : g_bad_digits
        $error("bin_to_bcd_seq: DIGITS must be in 1..10");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [BIN_W-1:0]   shift_q;
    logic [BCD_W-1:0]   digits_q;
    logic               sticky_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [BCD_W-1:0]   bcd_q;
    logic               overflow_q;
    logic               done_q;

    logic [BCD_W-1:0]   adj;
    logic [BCD_W-1:0]   digits_shifted;
    logic               carry_out;
    logic               last_shift;

    // Add-3 correction on each scratch digit (4-bit, never exceeds 12)
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
        assign adj[4*gi +: 4] = (digits_q[4*gi +: 4] >= 4'd5) ?
                                (digits_q[4*gi +: 4] + 4'd3) :
                                digits_q[4*gi +: 4];
    end

    // Shift the corrected digits left, pulling in the next binary MSB; the
    // top bit falls out into the sticky carry that marks truncation.
    assign digits_shifted = {adj[BCD_W-2:0], shift_q[BIN_W-1]};
    assign carry_out      = adj[BCD_W-1];
    assign last_shift     = (cnt_q == CNT_W'(BIN_W - 1));

`ifdef BCD_BLANK_EN
    logic [DIGITS-1:0]  blank_q;
    logic [DIGITS:0]    zero_from;
    logic [DIGITS-1:0]  blank_d;

    // zero_from[i]: final digit i and every higher digit are zero
    assign zero_from[DIGITS] = 1'b1;
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_blank
        assign zero_from[gi] = zero_from[gi+1] &&
                               (digits_shifted[4*gi +: 4] == 4'd0);
        if (gi == 0) begin : g_units
            assign blank_d[gi] = 1'b0;
        end else begin : g_upper
            assign blank_d[gi] = zero_from[gi];
        end
    end

    // Blank flags load alongside bcd and hold between conversions
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blank_q <= '0;
        end else if (state_q == SHIFT && last_shift) begin
            blank_q <= blank_d;
        end
    end

    assign bus.blank = blank_q;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: start only matters in IDLE; DONE lasts one cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = SHIFT;
            SHIFT:   if (last_shift) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: capture, shift/add-3 per cycle, and result load on the last shift
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q    <= '0;
            digits_q   <= '0;
            sticky_q   <= 1'b0;
            cnt_q      <= '0;
            bcd_q      <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        shift_q  <= bus.bin;
                        digits_q <= '0;
                        sticky_q <= 1'b0;
                        cnt_q    <= '0;
                    end
                end
                SHIFT: begin
                    digits_q <= digits_shifted;
                    shift_q  <= shift_q << 1;
                    sticky_q <= sticky_q | carry_out;
                    cnt_q    <= cnt_q + CNT_W'(1);
                    if (last_shift) begin
                        bcd_q      <= digits_shifted;
                        overflow_q <= sticky_q | carry_out;
                        done_q     <= 1'b1;
                    end
                end
                default: begin
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = done_q;
    assign bus.bcd      = bcd_q;
    assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq: a 3-digit and a 2-digit instance
// (both 8-bit input). Stimulus pushes model results; per-instance monitors
// pop and compare on every done pulse, including done timing.
module tb_bin_to_bcd_seq;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bin_to_bcd_seq_if #(.BIN_W(8), .DIGITS(3)) if3 ();
    bin_to_bcd_seq_if #(.BIN_W(8), .DIGITS(2)) if2 ();

    bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) dut3 (.clk(clk), .rst(rst), .bus(if3.slave));
    bin_to_bcd_seq #(.BIN_W(8), .DIGITS(2)) dut2 (.clk(clk), .rst(rst), .bus(if2.slave));

    typedef struct {
        longint bcd;
        longint ovf;
        longint blank;
        int     val;
        int     cyc;
    } exp_t;

    exp_t q3[$];
    exp_t q2[$];

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: decimal digits of v mod 10^digits by plain arithmetic
    function automatic exp_t model(input int unsigned v, input int digits);
        exp_t   e;
        longint m;
        longint r;
        longint p;
        m = 1;
        for (int i = 0; i < digits; i++) m = m * 10;
        r = longint'(v) % m;
        e.ovf = (longint'(v) >= m) ? 1 : 0;
        e.bcd = 0;
        e.blank = 0;
        p = 1;
        for (int i = 0; i < digits; i++) begin
            e.bcd = e.bcd | ((r / p % 10) << (4 * i));
            if (i > 0 && r < p) e.blank = e.blank | (longint'(1) << i);
            p = p * 10;
        end
        e.val = int'(v);
        e.cyc = 0;
        return e;
    endfunction

    function automatic bit busy_of(input bit s);
        return s ? if2.busy : if3.busy;
    endfunction

    // Monitor for the 3-digit instance
    always @(negedge clk) begin
        exp_t e;
        if (!rst && if3.done) begin
            if (q3.size() == 0) begin
                total++;
                bad++;
                $display("FAIL d3_unexpected_done: got done with bcd=%0h, expected no done", if3.bcd);
            end else begin
                e = q3.pop_front();
                chk($sformatf("d3_bcd(bin=%0d)", e.val), longint'(if3.bcd), e.bcd);
                chk($sformatf("d3_ovf(bin=%0d)", e.val), longint'(if3.overflow), e.ovf);
                chk($sformatf("d3_done_cycle(bin=%0d)", e.val), longint'(cyc), longint'(e.cyc + 8));
`ifdef BCD_BLANK_EN
                chk($sformatf("d3_blank(bin=%0d)", e.val), longint'(if3.blank), e.blank);
`endif
                $display("d3 done bin=%0d bcd=%03h ovf=%0b cycle=%0d", e.val, if3.bcd, if3.overflow, cyc);
            end
        end
    end

    // Monitor for the 2-digit instance
    always @(negedge clk) begin
        exp_t e;
        if (!rst && if2.done) begin
            if (q2.size() == 0) begin
                total++;
                bad++;
                $display("FAIL d2_unexpected_done: got done with bcd=%0h, expected no done", if2.bcd);
            end else begin
                e = q2.pop_front();
                chk($sformatf("d2_bcd(bin=%0d)", e.val), longint'(if2.bcd), e.bcd);
                chk($sformatf("d2_ovf(bin=%0d)", e.val), longint'(if2.overflow), e.ovf);
                chk($sformatf("d2_done_cycle(bin=%0d)", e.val), longint'(cyc), longint'(e.cyc + 8));
`ifdef BCD_BLANK_EN
                chk($sformatf("d2_blank(bin=%0d)", e.val), longint'(if2.blank), e.blank);
`endif
                $display("d2 done bin=%0d bcd=%02h ovf=%0b cycle=%0d", e.val, if2.bcd, if2.overflow, cyc);
            end
        end
    end

    // One conversion on instance s (0: 3-digit, 1: 2-digit); returns busy cycles
    task automatic convert(input bit s, input int unsigned v, output int bcnt);
        exp_t e;
        int   n;
        @(negedge clk);
        n = 0;
        while (busy_of(s) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("idle_wait_timeout", 1, 0);
        e = model(v, s ? 2 : 3);
        e.cyc = cyc + 1;
        if (s) begin
            if2.start = 1'b1; if2.bin = v[7:0]; q2.push_back(e);
        end else begin
            if3.start = 1'b1; if3.bin = v[7:0]; q3.push_back(e);
        end
        @(negedge clk);
        if3.start = 1'b0;
        if2.start = 1'b0;
        bcnt = 0;
        n = 0;
        while (busy_of(s) && n < 100) begin
            bcnt++;
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("busy_timeout", 1, 0);
        // results must hold after done has fallen
        repeat (3) @(negedge clk);
        if (s) begin
            chk($sformatf("d2_hold_bcd(bin=%0d)", v), longint'(if2.bcd), e.bcd);
`ifdef BCD_BLANK_EN
            chk($sformatf("d2_hold_blank(bin=%0d)", v), longint'(if2.blank), e.blank);
`endif
        end else begin
            chk($sformatf("d3_hold_bcd(bin=%0d)", v), longint'(if3.bcd), e.bcd);
            chk($sformatf("d3_hold_ovf(bin=%0d)", v), longint'(if3.overflow), e.ovf);
`ifdef BCD_BLANK_EN
            chk($sformatf("d3_hold_blank(bin=%0d)", v), longint'(if3.blank), e.blank);
`endif
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int   bc;
        int   n;
        int   e0;
        exp_t e;
        int   d3_list[8];
        int   d2_list[3];

        d3_list = '{0, 9, 10, 99, 100, 5, 40, 205};
        d2_list = '{99, 200, 255};

        if3.start = 1'b0; if3.bin = '0;
        if2.start = 1'b0; if2.bin = '0;

        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_busy", longint'(if3.busy), 0);
        chk("reset_done", longint'(if3.done), 0);
        chk("reset_bcd", longint'(if3.bcd), 0);
        chk("reset_ovf", longint'(if3.overflow), 0);
`ifdef BCD_BLANK_EN
        chk("reset_blank", longint'(if3.blank), 0);
`endif
        rst = 1'b0;

        // Full-scale value, busy span
        convert(1'b0, 255, bc);
        chk("d3_busy_cycles(bin=255)", longint'(bc), 9);

        foreach (d3_list[i]) convert(1'b0, d3_list[i], bc);
        foreach (d2_list[i]) convert(1'b1, d2_list[i], bc);

        // Handshake: start held during SHIFT and in DONE is ignored
        @(negedge clk);
        e = model(37, 3);
        e.cyc = cyc + 1;
        q3.push_back(e);
        if3.start = 1'b1; if3.bin = 8'd37;
        @(negedge clk);
        if3.start = 1'b0;
        @(negedge clk);
        if3.start = 1'b1; if3.bin = 8'd200;
        repeat (4) @(negedge clk);
        if3.start = 1'b0;
        n = 0;
        while (!if3.done && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("hs_done_timeout", 1, 0);
        if3.start = 1'b1; if3.bin = 8'd200;
        @(negedge clk);
        if3.start = 1'b0;
        repeat (12) @(negedge clk);
        chk("hs_no_restart_busy", longint'(if3.busy), 0);
        chk("hs_queue_drained", longint'(q3.size()), 0);
        chk("hs_bcd_kept", longint'(if3.bcd), 64'h037);
        $display("handshake sequence complete bcd=%03h", if3.bcd);

        // Asynchronous reset after shift 4 of a 255 conversion
        @(negedge clk);
        if3.start = 1'b1; if3.bin = 8'd255;
        e0 = cyc + 1;
        @(negedge clk);
        if3.start = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_mid_in_shift", longint'(cyc), longint'(e0 + 4));
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_busy", longint'(if3.busy), 0);
        chk("rst_mid_done", longint'(if3.done), 0);
        chk("rst_mid_bcd", longint'(if3.bcd), 0);
        chk("rst_mid_ovf", longint'(if3.overflow), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        chk("rst_no_resume_busy", longint'(if3.busy), 0);
        $display("reset mid-conversion complete");
        convert(1'b0, 128, bc);

        // Random values on both instances
        for (int i = 0; i < 30; i++) begin
            convert(1'b0, $urandom_range(0, 255), bc);
            convert(1'b1, $urandom_range(0, 255), bc);
        end

        repeat (5) @(negedge clk);
        chk("final_q3_empty", longint'(q3.size()), 0);
        chk("final_q2_empty", longint'(q2.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
